// File: rtl/elastic_pkg.sv
// Shared sizing helpers for the elastic FIFO and its pointer registers.
package elastic_pkg;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elastic_fifo_ptr.sv
// Wrap-around slot pointer; advances on inc, wraps NUM_SLOTS-1 -> 0 by explicit compare.
module elastic_fifo_ptr
  import elastic_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              inc,
  output logic [ptr_width(NUM_SLOTS)-1:0]   ptr
);

  localparam int unsigned PW = ptr_width(NUM_SLOTS);
  localparam logic [PW-1:0] LastSlot = PW'(NUM_SLOTS - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LastSlot) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/elastic_fifo_occ.sv
// Elastic circular-buffer FIFO with any depth, optional fall-through, occupancy
// count, almost-full flag and synchronous flush.
module elastic_fifo_occ
  import elastic_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 2,
  parameter int unsigned DATA_TYPE    = 32,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned AF_THRESHOLD = NUM_SLOTS - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [DATA_TYPE-1:0]              ins,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  output logic [DATA_TYPE-1:0]              outs,
  output logic                              outs_valid,
  input  logic                              outs_ready,
  output logic [cnt_width(NUM_SLOTS)-1:0]   count,
  output logic                              almost_full
);

  localparam int unsigned PW = ptr_width(NUM_SLOTS);
  localparam int unsigned CW = cnt_width(NUM_SLOTS);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, empty;
  logic                 bypass_fire, write_en, read_en;

  assign full  = (count_q == CW'(NUM_SLOTS));
  assign empty = (count_q == '0);

  assign ins_ready = ~rst & (~full | outs_ready);
  assign write_en  = ins_valid & ins_ready & ~bypass_fire;
  assign read_en   = outs_ready & ~empty;

  // An empty fall-through FIFO presents the input directly; a consumed bypass
  // word never touches storage.
  always_comb begin
    outs        = mem_q[head];
    outs_valid  = ~empty & ~rst;
    bypass_fire = 1'b0;
    if (FALL_THROUGH != 0 && empty) begin
      outs        = ins;
      outs_valid  = ins_valid & ~rst;
      bypass_fire = ins_valid & outs_ready & ~rst;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (write_en && !read_en) begin
      count_d = count_q + CW'(1);
    end else if (!write_en && read_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !flush) begin
      mem_q[tail] <= ins;
    end
  end

  elastic_fifo_ptr #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_head (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(read_en),
    .ptr(head)
  );

  elastic_fifo_ptr #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_tail (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(write_en),
    .ptr(tail)
  );

  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESHOLD));

endmodule

// File: tb/tb_elastic_fifo_occ.sv
// Directed bench for elastic_fifo_occ across four depth/fall-through configurations.
module tb_elastic_fifo_occ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: 3 slots, registered, AF=2
  logic       a_flush = 0, a_ins_valid = 0, a_outs_ready = 0;
  logic [7:0] a_ins = 0;
  logic       a_ins_ready, a_outs_valid, a_almost_full;
  logic [7:0] a_outs;
  logic [1:0] a_count;
  // B: 2 slots, registered
  logic       b_ins_valid = 0, b_outs_ready = 0;
  logic [7:0] b_ins = 0;
  logic       b_ins_ready, b_outs_valid, b_almost_full;
  logic [7:0] b_outs;
  logic [1:0] b_count;
  // C: 2 slots, fall-through
  logic       c_ins_valid = 0, c_outs_ready = 0;
  logic [7:0] c_ins = 0;
  logic       c_ins_ready, c_outs_valid, c_almost_full;
  logic [7:0] c_outs;
  logic [1:0] c_count;
  // D: 1 slot, registered
  logic       d_ins_valid = 0, d_outs_ready = 0;
  logic [7:0] d_ins = 0;
  logic       d_ins_ready, d_outs_valid, d_almost_full;
  logic [7:0] d_outs;
  logic [0:0] d_count;

  elastic_fifo_occ #(.NUM_SLOTS(3), .DATA_TYPE(8), .FALL_THROUGH(0), .AF_THRESHOLD(2)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .ins(a_ins), .ins_valid(a_ins_valid),
    .ins_ready(a_ins_ready), .outs(a_outs), .outs_valid(a_outs_valid),
    .outs_ready(a_outs_ready), .count(a_count), .almost_full(a_almost_full)
  );
  elastic_fifo_occ #(.NUM_SLOTS(2), .DATA_TYPE(8), .FALL_THROUGH(0), .AF_THRESHOLD(1)) u_b (
    .clk(clk), .rst(rst), .flush(1'b0), .ins(b_ins), .ins_valid(b_ins_valid),
    .ins_ready(b_ins_ready), .outs(b_outs), .outs_valid(b_outs_valid),
    .outs_ready(b_outs_ready), .count(b_count), .almost_full(b_almost_full)
  );
  elastic_fifo_occ #(.NUM_SLOTS(2), .DATA_TYPE(8), .FALL_THROUGH(1), .AF_THRESHOLD(1)) u_c (
    .clk(clk), .rst(rst), .flush(1'b0), .ins(c_ins), .ins_valid(c_ins_valid),
    .ins_ready(c_ins_ready), .outs(c_outs), .outs_valid(c_outs_valid),
    .outs_ready(c_outs_ready), .count(c_count), .almost_full(c_almost_full)
  );
  elastic_fifo_occ #(.NUM_SLOTS(1), .DATA_TYPE(8), .FALL_THROUGH(0), .AF_THRESHOLD(1)) u_d (
    .clk(clk), .rst(rst), .flush(1'b0), .ins(d_ins), .ins_valid(d_ins_valid),
    .ins_ready(d_ins_ready), .outs(d_outs), .outs_valid(d_outs_valid),
    .outs_ready(d_outs_ready), .count(d_count), .almost_full(d_almost_full)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic test_reset();
    c_ins_valid = 1'b1;
    c_ins = 8'h11;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b exp 0", a_ins_ready); end
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b exp 0", a_outs_valid); end
    checks++; if (c_outs_valid !== 1'b0) begin errors++; $display("FAIL rst_c_bypass_valid got %b exp 0", c_outs_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rst_a_count got %0d exp 0", a_count); end
    checks++; if (a_ins_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready_after got %b exp 1", a_ins_ready); end
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid_after got %b exp 0", a_outs_valid); end
    checks++; if (a_almost_full !== 1'b0) begin errors++; $display("FAIL rst_a_af got %b exp 0", a_almost_full); end
    checks++; if (c_outs_valid !== 1'b1) begin errors++; $display("FAIL rst_c_follow got %b exp 1", c_outs_valid); end
    c_ins_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [3];
    vals[0] = 8'd3; vals[1] = 8'd4; vals[2] = 8'd5;
    a_outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_ins = vals[i];
      a_ins_valid = 1'b1;
      #1;
      checks++; if (a_count !== 2'(i)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", i, a_count, i); end
      checks++; if (a_almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af%0d got %b exp %b", i, a_almost_full, i >= 2); end
    end
    @(negedge clk);
    a_ins_valid = 1'b0;
    #1;
    checks++; if (a_count !== 2'd3) begin errors++; $display("FAIL fill_full_count got %0d exp 3", a_count); end
    checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_drop got %b exp 0", a_ins_ready); end
    checks++; if (a_almost_full !== 1'b1) begin errors++; $display("FAIL fill_af_full got %b exp 1", a_almost_full); end
    @(negedge clk);
    a_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_outs !== vals[i]) begin errors++; $display("FAIL drain_data%0d got %0d exp %0d", i, a_outs, vals[i]); end
      checks++; if (a_count !== 2'(3 - i)) begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", i, a_count, 3 - i); end
      @(negedge clk);
    end
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL drain_empty got %0d exp 0", a_count); end
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", a_outs_valid); end
  endtask

  task automatic test_stream();
    a_outs_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      a_ins = 8'(k);
      a_ins_valid = (k < 10);
      #1;
      if (k >= 1) begin
        checks++; if (a_outs_valid !== 1'b1 || a_outs !== 8'(k - 1)) begin
          errors++; $display("FAIL stream_out%0d got %0d/%b exp %0d/1", k, a_outs, a_outs_valid, k - 1);
        end
      end
      checks++; if (a_count > 2'd1) begin errors++; $display("FAIL stream_count%0d got %0d exp <=1", k, a_count); end
    end
    @(negedge clk);
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", a_count); end
  endtask

  task automatic test_full_replace();
    b_outs_ready = 1'b0;
    @(negedge clk); b_ins = 8'd10; b_ins_valid = 1'b1;
    @(negedge clk); b_ins = 8'd11;
    @(negedge clk); b_ins = 8'd12; b_outs_ready = 1'b1;
    #1;
    checks++; if (b_count !== 2'd2) begin errors++; $display("FAIL repl_full_count got %0d exp 2", b_count); end
    checks++; if (b_ins_ready !== 1'b1) begin errors++; $display("FAIL repl_ready got %b exp 1", b_ins_ready); end
    checks++; if (b_outs !== 8'd10) begin errors++; $display("FAIL repl_out10 got %0d exp 10", b_outs); end
    @(negedge clk); b_ins_valid = 1'b0;
    #1;
    checks++; if (b_count !== 2'd2) begin errors++; $display("FAIL repl_count_kept got %0d exp 2", b_count); end
    checks++; if (b_outs !== 8'd11) begin errors++; $display("FAIL repl_out11 got %0d exp 11", b_outs); end
    @(negedge clk);
    #1;
    checks++; if (b_outs !== 8'd12) begin errors++; $display("FAIL repl_out12 got %0d exp 12", b_outs); end
    @(negedge clk);
    #1;
    checks++; if (b_outs_valid !== 1'b0) begin errors++; $display("FAIL repl_empty got %b exp 0", b_outs_valid); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    c_ins = 8'hAB; c_ins_valid = 1'b1; c_outs_ready = 1'b1;
    #1;
    checks++; if (c_outs_valid !== 1'b1 || c_outs !== 8'hAB) begin
      errors++; $display("FAIL byp_same_cycle got %h/%b exp ab/1", c_outs, c_outs_valid);
    end
    @(negedge clk);
    c_ins_valid = 1'b0;
    #1;
    checks++; if (c_count !== 2'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", c_count); end
    checks++; if (c_outs_valid !== 1'b0) begin errors++; $display("FAIL byp_not_stored got %b exp 0", c_outs_valid); end
    @(negedge clk);
    c_ins_valid = 1'b1; c_outs_ready = 1'b0;
    @(negedge clk);
    c_ins_valid = 1'b0; c_ins = 8'h00;
    #1;
    checks++; if (c_count !== 2'd1) begin errors++; $display("FAIL byp_stored_count got %0d exp 1", c_count); end
    checks++; if (c_outs_valid !== 1'b1 || c_outs !== 8'hAB) begin
      errors++; $display("FAIL byp_stored_out got %h/%b exp ab/1", c_outs, c_outs_valid);
    end
    @(negedge clk);
    c_outs_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (c_count !== 2'd0) begin errors++; $display("FAIL byp_drained got %0d exp 0", c_count); end
  endtask

  task automatic test_depth1();
    d_outs_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      d_ins = 8'(k + 1);
      d_ins_valid = (k < 3);
      #1;
      if (k < 3) begin
        checks++; if (d_ins_ready !== 1'b1) begin errors++; $display("FAIL d1_ready%0d got %b exp 1", k, d_ins_ready); end
      end
      if (k >= 1) begin
        checks++; if (d_outs_valid !== 1'b1 || d_outs !== 8'(k)) begin
          errors++; $display("FAIL d1_out%0d got %0d/%b exp %0d/1", k, d_outs, d_outs_valid, k);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (d_outs_valid !== 1'b0) begin errors++; $display("FAIL d1_empty got %b exp 0", d_outs_valid); end
  endtask

  task automatic test_flush();
    a_outs_ready = 1'b0;
    @(negedge clk); a_ins = 8'd1; a_ins_valid = 1'b1;
    @(negedge clk); a_ins = 8'd2;
    @(negedge clk); a_ins = 8'h55; a_flush = 1'b1;
    #1;
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got %0d exp 2", a_count); end
    checks++; if (a_ins_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", a_ins_ready); end
    @(negedge clk); a_flush = 1'b0; a_ins_valid = 1'b0; a_outs_ready = 1'b1;
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", a_count); end
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", a_outs_valid); end
    @(negedge clk);
    #1;
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL flush_no55 got %b/%h exp 0", a_outs_valid, a_outs); end
  endtask

  task automatic test_rst_mid();
    a_outs_ready = 1'b0;
    @(negedge clk); a_ins = 8'd7; a_ins_valid = 1'b1;
    @(negedge clk); a_ins = 8'd8;
    @(negedge clk); a_ins = 8'd9; rst = 1'b1;
    #1;
    checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", a_ins_ready); end
    @(negedge clk);
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", a_count); end
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", a_outs_valid); end
    checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_held got %b exp 0", a_ins_ready); end
    @(negedge clk); rst = 1'b0; a_ins_valid = 1'b0;
    #1;
    checks++; if (a_ins_ready !== 1'b1 || a_count !== 2'd0) begin
      errors++; $display("FAIL rstmid_release got %b/%0d exp 1/0", a_ins_ready, a_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_replace();
    test_bypass();
    test_depth1();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
